// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file constants, writeback entry type and result mux
package cpu_pkg;
  localparam logic [3:0] REG_PC = 4'd15;
  localparam int WIDTH = 32;
  typedef struct packed {
    logic             valid;
    logic             wr;
    logic             mem_to_reg;
    logic [3:0]       a3;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] read_data;
  } wb_entry_t;
  function automatic logic [WIDTH-1:0] mux2(input logic sel, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return sel ? b : a;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters feeding decode hazard detection
module reg_scoreboard import cpu_pkg::*; #(
  parameter int CNTW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_en,
  input  logic [3:0] inc_a3,
  input  logic       dec_en,
  input  logic [3:0] dec_a3,
  input  logic       can_en,
  input  logic [3:0] can_a3,
  input  logic [3:0] ra1,
  input  logic [3:0] ra2,
  output logic       hazard,
  output logic       sb_full
);
  localparam int MAX = 2**CNTW - 1;
  logic [CNTW-1:0] cnt_q [16];
  logic [CNTW-1:0] cnt_d [16];
  function automatic logic [CNTW-1:0] step(input logic [CNTW-1:0] c, input logic i, input logic d, input logic x);
    int n;
    n = int'(c) + int'(i) - int'(d) - int'(x);
    return (n < 0) ? '0 : (n > MAX) ? '1 : CNTW'(n);
  endfunction
  // Net change per register is issue minus retire minus flush-cancel, clamped; R15 is never reserved
  always_comb begin
    for (int r = 0; r < 16; r++)
      cnt_d[r] = step(cnt_q[r],
                      inc_en && inc_a3 == 4'(r) && 4'(r) != REG_PC,
                      dec_en && dec_a3 == 4'(r),
                      can_en && can_a3 == 4'(r) && 4'(r) != REG_PC);
  end
  // Counter bank; asynchronous clear so hazards vanish as soon as reset asserts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      for (int r = 0; r < 16; r++) cnt_q[r] <= '0;
    else
      cnt_q <= cnt_d;
  end
  // Hazard on either read port; full while any counter is saturated
  always_comb begin
    hazard  = (cnt_q[ra1] != '0) || (cnt_q[ra2] != '0);
    sb_full = 1'b0;
    for (int r = 0; r < 16; r++) sb_full = sb_full | (cnt_q[r] == CNTW'(MAX));
  end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: writeback register, register-file write port, PC redirect and hazard scoreboard
module writeback_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             m_valid,
  input  logic             m_RegWrite,
  input  logic             m_NoWrite,
  input  logic             m_MemtoReg,
  input  logic [3:0]       m_A3,
  input  logic [WIDTH-1:0] m_ALUResult,
  input  logic [WIDTH-1:0] m_ReadData,
  input  logic             d_issue,
  input  logic             d_RegWrite,
  input  logic             d_NoWrite,
  input  logic [3:0]       d_A3,
  input  logic [3:0]       RA1,
  input  logic [3:0]       RA2,
  output logic             WE3,
  output logic [3:0]       A3,
  output logic [WIDTH-1:0] WD3,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_next,
  output logic             hazard,
  output logic             sb_full
);
  import cpu_pkg::*;
  wb_entry_t        wb_q, wb_d;
  logic [WIDTH-1:0] res;
  // Capture the memory-stage entry unless stalled; a flush clears validity even while stalled
  always_comb begin
    wb_d = wb_q;
    if (!stall) begin
      wb_d.valid      = m_valid & ~flush;
      wb_d.wr         = m_valid & ~flush & m_RegWrite & ~m_NoWrite;
      wb_d.mem_to_reg = m_MemtoReg;
      wb_d.a3         = m_A3;
      wb_d.alu_result = m_ALUResult;
      wb_d.read_data  = m_ReadData;
    end else if (flush) begin
      wb_d.valid = 1'b0;
      wb_d.wr    = 1'b0;
    end
  end
  // Writeback register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_q <= '0;
    else      wb_q <= wb_d;
  end
  assign res     = mux2(wb_q.mem_to_reg, wb_q.alu_result, wb_q.read_data);
  assign WE3     = wb_q.valid & wb_q.wr & (wb_q.a3 != REG_PC);
  assign pc_load = wb_q.valid & wb_q.wr & (wb_q.a3 == REG_PC);
  assign A3      = wb_q.a3;
  assign WD3     = res;
  assign pc_next = res;
  reg_scoreboard #(.CNTW(CNTW)) u_sb (
    .clk    (clk),
    .rst    (rst),
    .inc_en (d_issue & ~stall & d_RegWrite & ~d_NoWrite),
    .inc_a3 (d_A3),
    .dec_en (WE3),
    .dec_a3 (A3),
    .can_en (flush & m_valid & m_RegWrite & ~m_NoWrite),
    .can_a3 (m_A3),
    .ra1    (RA1),
    .ra2    (RA2),
    .hazard (hazard),
    .sb_full(sb_full)
  );
endmodule
